// File: rtl/clkdiv_cfg_pkg.sv
// Shared types and defaults for the clock-divider configuration sequencer.
package clkdiv_cfg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGate,
        StLoad,
        StSettle,
        StDone
    } state_e;

    localparam int unsigned RST_RATIO_D   = 2;
    localparam int unsigned GATE_CYCLES_D = 4;

    // Settle length is one full output period; ratio 0 still needs one cycle.
    function automatic int unsigned eff_settle(input int unsigned ratio);
        return (ratio == 0) ? 1 : ratio;
    endfunction

endpackage

// File: rtl/clkdiv_rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips to the other requester on every accepted grant.
module clkdiv_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = valid_i;
        if (valid_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i && (valid_i != 2'b00)) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/clkdiv_cfg_ctrl.sv
// Gate/load/settle sequencer for the divider ratio and enable, serving two requesters.
// Optional reject of low ratios is compiled in with CLKDIV_CFG_RANGE_CHK_EN.
module clkdiv_cfg_ctrl
    import clkdiv_cfg_pkg::*;
#(
    parameter int unsigned          DIV_WIDTH   = 8,
    parameter logic [DIV_WIDTH-1:0] RST_RATIO   = DIV_WIDTH'(RST_RATIO_D),
    parameter int unsigned          GATE_CYCLES = GATE_CYCLES_D,
    parameter int unsigned          MIN_RATIO   = 2
) (
    input  logic                 i_ref_clk,
    input  logic                 i_rst,
    input  logic                 i_req0_valid,
    input  logic [DIV_WIDTH-1:0] i_req0_ratio,
    output logic                 o_req0_ack,
    input  logic                 i_req1_valid,
    input  logic [DIV_WIDTH-1:0] i_req1_ratio,
    output logic                 o_req1_ack,
    output logic [DIV_WIDTH-1:0] o_div_ratio,
    output logic                 o_clk_en,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int unsigned CNT_W = DIV_WIDTH + 1;

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] ratio_q, ratio_d;
    logic [DIV_WIDTH-1:0] cap_q, cap_d;
    logic                 en_q, en_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 gnt1_q, gnt1_d;

    logic [1:0]           gnt;
    logic                 arb_accept;
    logic [DIV_WIDTH-1:0] req_ratio;
    logic                 req_en_tgt;
    logic [CNT_W-1:0]     settle_last;

    assign arb_accept  = (state_q == StIdle) && (i_req0_valid || i_req1_valid);
    assign req_ratio   = gnt[1] ? i_req1_ratio : i_req0_ratio;
    assign req_en_tgt  = (req_ratio >= DIV_WIDTH'(2));
    assign settle_last = CNT_W'(eff_settle(32'(cap_q)) - 1);

    clkdiv_rr_arb2 u_arb (
        .clk_i    (i_ref_clk),
        .rst_i    (i_rst),
        .valid_i  ({i_req1_valid, i_req0_valid}),
        .accept_i (arb_accept),
        .gnt_o    (gnt)
    );

`ifdef CLKDIV_CFG_RANGE_CHK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        ratio_d = ratio_q;
        cap_d   = cap_q;
        en_d    = en_q;
        cnt_d   = cnt_q;
        gnt1_d  = gnt1_q;
`ifdef CLKDIV_CFG_RANGE_CHK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (arb_accept) begin
                    cap_d  = req_ratio;
                    gnt1_d = gnt[1];
                    cnt_d  = '0;
`ifdef CLKDIV_CFG_RANGE_CHK_EN
                    err_d  = 1'b0;
                    if (32'(req_ratio) < MIN_RATIO) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else
`endif
                    if ((req_ratio == ratio_q) && (en_q == req_en_tgt)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StGate;
                        en_d    = 1'b0;
                    end
                end
            end
            StGate: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(GATE_CYCLES - 1)) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                // Enable is registered here so it rises together with the new ratio.
                ratio_d = cap_q;
                en_d    = (cap_q >= DIV_WIDTH'(2));
                cnt_d   = '0;
                state_d = StSettle;
            end
            StSettle: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == settle_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            ratio_q <= RST_RATIO;
            cap_q   <= RST_RATIO;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            gnt1_q  <= 1'b0;
`ifdef CLKDIV_CFG_RANGE_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ratio_q <= ratio_d;
            cap_q   <= cap_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            gnt1_q  <= gnt1_d;
`ifdef CLKDIV_CFG_RANGE_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign o_div_ratio = ratio_q;
    assign o_clk_en    = en_q;
    assign o_busy      = (state_q != StIdle);
    assign o_req0_ack  = (state_q == StDone) && !gnt1_q;
    assign o_req1_ack  = (state_q == StDone) && gnt1_q;
`ifdef CLKDIV_CFG_RANGE_CHK_EN
    assign o_err       = (state_q == StDone) && err_q;
`else
    assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// Directed self-checking bench for clkdiv_cfg_ctrl with GATE_CYCLES=4 and RST_RATIO=2.
module tb_clkdiv_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_ratio = 8'd0;
    logic       req0_ack;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_ratio = 8'd0;
    logic       req1_ack;
    logic [7:0] div_ratio;
    logic       clk_en;
    logic       busy;
    logic       err;

    int total = 0;
    int bad   = 0;

    logic       en_log    [0:400];
    logic [7:0] ratio_log [0:400];
    logic       busy_log  [0:400];
    logic       err_seen;
    logic       other_ack;

    clkdiv_cfg_ctrl #(
        .DIV_WIDTH   (8),
        .RST_RATIO   (8'd2),
        .GATE_CYCLES (4),
        .MIN_RATIO   (2)
    ) dut (
        .i_ref_clk    (clk),
        .i_rst        (rst),
        .i_req0_valid (req0_valid),
        .i_req0_ratio (req0_ratio),
        .o_req0_ack   (req0_ack),
        .i_req1_valid (req1_valid),
        .i_req1_ratio (req1_ratio),
        .o_req1_ack   (req1_ack),
        .o_div_ratio  (div_ratio),
        .o_clk_en     (clk_en),
        .o_busy       (busy),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_en(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += int'(en_log[i]);
        return n;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts negedges from the call; drops the served valid when its ack is seen.
    task automatic wait_ack(input int idx, input int exp_cyc, input logic exp_err,
                            input string tag);
        int got = -1;
        en_log[0]    = clk_en;
        ratio_log[0] = div_ratio;
        busy_log[0]  = busy;
        err_seen     = 1'b0;
        other_ack    = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            en_log[c]    = clk_en;
            ratio_log[c] = div_ratio;
            busy_log[c]  = busy;
            if ((idx == 0) ? req0_ack : req1_ack) begin
                got       = c;
                err_seen  = err;
                other_ack = (idx == 0) ? req1_ack : req0_ack;
                break;
            end
        end
        if (idx == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
        check({tag, "_ack_cycle"}, got, exp_cyc);
        check({tag, "_err"}, {31'd0, err_seen}, {31'd0, exp_err});
        check({tag, "_other_ack"}, {31'd0, other_ack}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_ack;

        // Reset state and idle hold.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_hold", {26'd0, div_ratio, clk_en, busy, req0_ack, req1_ack, err},
                  {26'd0, 8'd2, 5'b00000});
        end

        // Full path 2 -> 6: gate 1-4, load 5, settle 6-11, ack 12.
        req0_ratio = 8'd6;
        req0_valid = 1'b1;
        wait_ack(0, 12, 1'b0, "r0_6");
        check("r0_6_busy_c1", {31'd0, busy_log[1]}, 32'd1);
        check("r0_6_en_low_1_5", count_en(1, 5), 0);
        check("r0_6_ratio_c5", {24'd0, ratio_log[5]}, 32'd2);
        check("r0_6_ratio_c6", {24'd0, ratio_log[6]}, 32'd6);
        check("r0_6_en_high_6_11", count_en(6, 11), 6);
        @(negedge clk);
        check("r0_6_ack_one_cycle", {30'd0, req0_ack, req1_ack}, 32'd0);
        check("r0_6_idle", {31'd0, busy}, 32'd0);

        // Simultaneous requests after reset: req0 (4) first, then req1 (10).
        do_reset();
        req0_ratio = 8'd4;
        req1_ratio = 8'd10;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_ack(0, 10, 1'b0, "both_r0");
        check("both_r0_ratio", {24'd0, div_ratio}, 32'd4);
        // First negedge below is req1's IDLE sample cycle, so ack lands at 4+10+2+1.
        wait_ack(1, 17, 1'b0, "both_r1");
        check("both_r1_idle_c1", {31'd0, busy_log[1]}, 32'd0);
        check("both_r1_en_low_2_6", count_en(2, 6), 0);
        check("both_r1_ratio_c6", {24'd0, ratio_log[6]}, 32'd4);
        check("both_r1_ratio_c7", {24'd0, ratio_log[7]}, 32'd10);
        check("both_r1_en_high_7_16", count_en(7, 16), 10);

        // Fast path: same ratio, already enabled.
        @(negedge clk);
        req1_ratio = 8'd10;
        req1_valid = 1'b1;
        wait_ack(1, 1, 1'b0, "fast_r1");
        check("fast_r1_en_kept", count_en(0, 1), 2);
        check("fast_r1_ratio", {24'd0, div_ratio}, 32'd10);

        // Pointer now favours req0: req0 (10, fast) wins, then req1 (3) full path.
        @(negedge clk);
        req0_ratio = 8'd10;
        req1_ratio = 8'd3;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_ack(0, 1, 1'b0, "ptr_r0");
        wait_ack(1, 10, 1'b0, "ptr_r1");
        check("ptr_r1_ratio", {24'd0, div_ratio}, 32'd3);

        // Ratio 1: pass-through, or rejected when the range check is built in.
        @(negedge clk);
        req0_ratio = 8'd1;
        req0_valid = 1'b1;
`ifdef CLKDIV_CFG_RANGE_CHK_EN
        wait_ack(0, 1, 1'b1, "r0_1");
        check("r0_1_ratio_kept", {24'd0, div_ratio}, 32'd3);
        check("r0_1_en_kept", {31'd0, clk_en}, 32'd1);
`else
        wait_ack(0, 7, 1'b0, "r0_1");
        check("r0_1_ratio", {24'd0, div_ratio}, 32'd1);
        check("r0_1_en", {31'd0, clk_en}, 32'd0);
        check("r0_1_en_low_1_6", count_en(1, 6), 0);
`endif

        // Reset during SETTLE (cycle 7 of a ratio-8 change) aborts without ack.
        @(negedge clk);
        req0_ratio = 8'd8;
        req0_valid = 1'b1;
        repeat (7) @(negedge clk);
        check("abort_in_settle", {30'd0, busy, clk_en}, 32'd3);
        check("abort_ratio_loaded", {24'd0, div_ratio}, 32'd8);
        rst        = 1'b1;
        req0_valid = 1'b0;
        @(negedge clk);
        check("abort_reset_state", {28'd0, div_ratio == 8'd2, clk_en, busy, req0_ack},
              32'd8);
        rst     = 1'b0;
        any_ack = 1'b0;
        repeat (5) begin
            @(negedge clk);
            any_ack = any_ack | req0_ack | req1_ack | busy;
        end
        check("abort_no_ack", {31'd0, any_ack}, 32'd0);
        req0_valid = 1'b1;
        wait_ack(0, 14, 1'b0, "rereq");
        check("rereq_outputs", {23'd0, div_ratio, clk_en}, {23'd0, 8'd8, 1'b1});

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clkdiv_cfg_ctrl.md
Name: clkdiv_cfg_ctrl

Overview:
Configuration sequencer for the programmable clock divider. It arbitrates ratio-change requests from two requesters, for example the UART TX and RX prescale logic, and drives the divider's ratio and enable inputs. Each change follows a gate, load, settle sequence so the divided clock never sees a ratio change mid-period. It sits beside the divider in the clock/reset domain of i_ref_clk.

Parameters:
DIV_WIDTH, 8, width of the ratio bus. Must match the divider.
RST_RATIO, 8'd2, ratio driven out of reset.
GATE_CYCLES, 4, number of cycles the divider enable is held low before a new ratio is loaded. Minimum 1.
MIN_RATIO, 2, lowest ratio accepted when the range-check feature is compiled in.

Ports:
i_ref_clk  in  1  Reference clock; the only clock.
i_rst  in  1  Reset: synchronous, active-high.
i_req0_valid  in  1  Requester 0 change request. Held high until o_req0_ack.
i_req0_ratio  in  DIV_WIDTH  Requester 0 target ratio. Stable while valid is high.
o_req0_ack  out  1  One-cycle completion pulse for requester 0.
i_req1_valid  in  1  Requester 1 change request.
i_req1_ratio  in  DIV_WIDTH  Requester 1 target ratio.
o_req1_ack  out  1  One-cycle completion pulse for requester 1.
o_div_ratio  out  DIV_WIDTH  Drives the divider ratio input.
o_clk_en  out  1  Drives the divider enable input.
o_busy  out  1  High in every state except IDLE.
o_err  out  1  One-cycle reject pulse, coincident with ack. Tied to 0 when the feature is off.

Behaviour:
- Reset (sampled on the i_ref_clk edge while i_rst=1):
  - state=IDLE, o_div_ratio=RST_RATIO, o_clk_en=0 (divider passes the reference clock).
  - Both acks=0, o_busy=0, o_err=0, RR pointer=req0.
- Reset mid-sequence aborts the sequence immediately. No ack is issued; requesters must re-request.
- States: IDLE, GATE, LOAD, SETTLE, DONE.
- IDLE:
  - If any valid is high, grant one requester round-robin. Only one valid high: grant it. Both high: grant the pointer's requester. The pointer moves to the other requester after every grant.
  - Capture the granted ratio into cap_ratio.
  - If cap_ratio==o_div_ratio and o_clk_en already equals en_target, go directly to DONE (fast path).
  - Otherwise go to GATE.
- en_target = (cap_ratio>=2). Ratios 0 and 1 mean pass-through, enable low.
- GATE: o_clk_en=0 for exactly GATE_CYCLES cycles, counted by the shared counter, then go to LOAD.
- LOAD, 1 cycle: o_div_ratio<=cap_ratio, o_clk_en still 0. Go to SETTLE with counter cleared.
- SETTLE: o_clk_en=en_target. Stay R cycles, where R=max(cap_ratio,1), i.e. one full output period. Then go to DONE.
- DONE, 1 cycle: pulse the granted requester's ack, then go to IDLE. Valid may be sampled again in the next IDLE cycle.
- Latency, taking the cycle valid is first sampled in IDLE as cycle 0:
  - Full path: ack high in cycle GATE_CYCLES+R+2.
  - Fast path: ack high in cycle 1.
- A requester dropping valid mid-sequence does not abort it; ack is still pulsed.
- A request arriving while busy waits in the arbiter. No loss, no queue beyond the held valid.
- o_div_ratio and o_clk_en change only on state transitions (registered outputs). No glitch paths.
- Counter width: DIV_WIDTH+1 bits, so R=255 and GATE_CYCLES up to 255 do not wrap.

Optional Feature:
CLKDIV_CFG_RANGE_CHK_EN
- Defined: a captured ratio below MIN_RATIO skips GATE/LOAD/SETTLE and goes IDLE->DONE with o_err=1 alongside ack. o_div_ratio and o_clk_en are unchanged.
- Undefined: every ratio is applied, 0 and 1 as pass-through, and o_err is constant 0.

Decomposition:
- Package clkdiv_cfg_pkg: state enum (IDLE, GATE, LOAD, SETTLE, DONE), default constants RST_RATIO_D and GATE_CYCLES_D, and a function eff_settle(ratio) returning max(ratio,1).
- One sub-module, clkdiv_rr_arb2: 2-way round-robin arbiter. Inputs: valids and a grant-accept strobe. Outputs: one-hot grant, with the pointer updated on accept.
- The FSM and counter stay in the top module, which also instantiates the existing divider in its test harness only.

Test Plan:
- Reset release, no requests -> o_div_ratio=2, o_clk_en=0, o_busy=0 held for 20 cycles.
- req0 ratio=6, GATE_CYCLES=4 -> o_clk_en low cycles 1-5, o_div_ratio=6 from cycle 6, o_clk_en=1 cycles 6-11, ack0 pulse in cycle 12. The divider output shows no short pulse.
- req0=4 and req1=10 raised in the same cycle after reset -> req0 served first; req1 acked after a second full sequence, with R=10. Pointer then favours req0.
- Repeat req1 ratio=10 while 10 is active and enabled -> ack1 in cycle 1, o_clk_en never drops.
- req0 ratio=1 -> o_div_ratio=1, o_clk_en=0 after LOAD, ack at cycle GATE_CYCLES+3. With CLKDIV_CFG_RANGE_CHK_EN -> ack and o_err in cycle 1, outputs unchanged.
- Assert i_rst during SETTLE -> next cycle IDLE, ratio=2, en=0, no ack. A re-request completes normally.
